// File: rtl/aes_round_sequencer_if.sv
// Block-input, round-key, round-function and ciphertext signals of the AES round sequencer.
// master = block source / key schedule / round-function side, slave = sequencer.
interface aes_round_sequencer_if #(
  parameter int DATA_W = 128,
  parameter int RND_W  = 4
);
  logic              start_valid;
  logic              start_ready;
  logic [DATA_W-1:0] data_in;
  logic              rk_req;
  logic [RND_W-1:0]  rk_idx;
  logic              rk_valid;
  logic [DATA_W-1:0] rk_data;
  logic [DATA_W-1:0] rnd_state;
  logic              rnd_last;
  logic [DATA_W-1:0] rnd_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              busy;

  modport master (
    output start_valid, data_in, rk_valid, rk_data, rnd_result, out_ready,
    input  start_ready, rk_req, rk_idx, rnd_state, rnd_last, out_valid, data_out, busy
  );

  modport slave (
    input  start_valid, data_in, rk_valid, rk_data, rnd_result, out_ready,
    output start_ready, rk_req, rk_idx, rnd_state, rnd_last, out_valid, data_out, busy
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption round sequencer: owns the state register and round counter,
// fetches round keys by index and folds the external round-function result into the state.
module aes_round_sequencer #(
  parameter int DATA_W = 128,
  parameter int NR     = 10,
  parameter int RND_W  = 4
) (
  input logic               clk,
  input logic               reset,
  aes_round_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    KEY_WAIT = 2'd1,
    DONE     = 2'd2
  } fsm_t;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);
  localparam logic [RND_W-1:0] RND_ZERO = {RND_W{1'b0}};
  localparam logic [RND_W-1:0] RND_ONE  = RND_W'(1);

  fsm_t              fsm_r;
  fsm_t              fsm_s;
  logic [DATA_W-1:0] state_r;
  logic [DATA_W-1:0] state_s;
  logic [RND_W-1:0]  round_r;
  logic [RND_W-1:0]  round_s;
  logic              start_ready_r;
  logic              rk_req_r;
  logic              out_valid_r;
  logic              busy_r;
  logic              rnd_last_r;

  // Next-state, next-data and next-round decode
  always_comb begin
    fsm_s   = fsm_r;
    state_s = state_r;
    round_s = round_r;
    case (fsm_r)
      IDLE: begin
        if (bus.start_valid) begin
          state_s = bus.data_in;
          round_s = RND_ZERO;
          fsm_s   = KEY_WAIT;
        end else begin
          fsm_s = IDLE;
        end
      end
      KEY_WAIT: begin
        if (bus.rk_valid) begin
          // Round 0 is the initial AddRoundKey; later rounds go through the round function first.
          state_s = ((round_r == RND_ZERO) ? state_r : bus.rnd_result) ^ bus.rk_data;
          if (round_r == LAST_RND) begin
            fsm_s = DONE;
          end else begin
            round_s = round_r + RND_ONE;
          end
        end else begin
          fsm_s = KEY_WAIT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_s = IDLE;
        end else begin
          fsm_s = DONE;
        end
      end
      default: begin
        fsm_s = IDLE;
      end
    endcase
  end

  // State registers plus handshake flags registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_r         <= IDLE;
      state_r       <= {DATA_W{1'b0}};
      round_r       <= RND_ZERO;
      start_ready_r <= 1'b1;
      rk_req_r      <= 1'b0;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      rnd_last_r    <= 1'b0;
    end else begin
      fsm_r         <= fsm_s;
      state_r       <= state_s;
      round_r       <= round_s;
      start_ready_r <= (fsm_s == IDLE);
      rk_req_r      <= (fsm_s == KEY_WAIT);
      out_valid_r   <= (fsm_s == DONE);
      busy_r        <= (fsm_s != IDLE);
      rnd_last_r    <= (round_s == LAST_RND);
    end
  end

  assign bus.start_ready = start_ready_r;
  assign bus.rk_req      = rk_req_r;
  assign bus.rk_idx      = round_r;
  assign bus.rnd_state   = state_r;
  assign bus.rnd_last    = rnd_last_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.data_out    = state_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: a behavioural AES model supplies round keys and the round function,
// and predicts ciphertext and handshake timing for NR=10 and NR=14 sequencers.
module tb_aes_round_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_round_sequencer_if #(.DATA_W(128), .RND_W(4)) ifa ();
  aes_round_sequencer_if #(.DATA_W(128), .RND_W(4)) ifb ();

  aes_round_sequencer #(.DATA_W(128), .NR(10), .RND_W(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  aes_round_sequencer #(.DATA_W(128), .NR(14), .RND_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  logic [7:0]   sbox [0:255];
  logic [127:0] rk10 [0:15];
  logic [127:0] rk14 [0:15];
  int           stall_n [0:15];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, a, b;
    p = 8'h00; a = x; b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // One AES round: SubBytes, ShiftRows and, unless last, MixColumns.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0]   a [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[c*4+r] = a[((c+r)%4)*4+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        c0 = t[c*4]; c1 = t[c*4+1]; c2 = t[c*4+2]; c3 = t[c*4+3];
        t[c*4]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
        t[c*4+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
        t[c*4+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
        t[c*4+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input bit to14);
    logic [31:0] w [0:63];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) begin
      if (to14) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else      rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr, input bit use14);
    logic [127:0] s;
    s = pt ^ (use14 ? rk14[0] : rk10[0]);
    for (int r = 1; r <= nr; r++) s = aes_round(s, r == nr) ^ (use14 ? rk14[r] : rk10[r]);
    return s;
  endfunction

  // Key schedule and round function as seen by the sequencers; rk_data is garbage unless valid.
  always_comb begin
    ifa.rk_data    = ifa.rk_valid ? rk10[ifa.rk_idx] : 128'hdeadbeef_0badf00d_5a5a5a5a_c3c3c3c3;
    ifa.rnd_result = aes_round(ifa.rnd_state, ifa.rnd_last);
    ifb.rk_data    = rk14[ifb.rk_idx];
    ifb.rnd_result = aes_round(ifb.rnd_state, ifb.rnd_last);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check_eq({tag, "_flags"}, 128'({ifa.start_ready, ifa.rk_req, ifa.rk_idx, ifa.out_valid,
                                    ifa.busy, ifa.rnd_last}), 128'(9'b1_0_0000_0_0_0));
    check_eq({tag, "_data_out"}, ifa.data_out, 128'h0);
    check_eq({tag, "_rnd_state"}, ifa.rnd_state, 128'h0);
  endtask

  // Push one block through dut_a with the stalls in stall_n and bp cycles of out_ready low.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] exp_ct, input int bp,
                           input string tag);
    int         lat, total_stall, left;
    logic [3:0] exp_idx;
    bit         done;
    lat = 0; total_stall = 0; exp_idx = 4'd0; done = 1'b0;
    for (int i = 0; i <= 10; i++) total_stall += stall_n[i];
    check_eq({tag, "_ready"}, 128'(ifa.start_ready), 128'h1);
    ifa.start_valid = 1'b1;
    ifa.data_in     = pt;
    tick();
    ifa.start_valid = 1'b0;
    ifa.data_in     = {$urandom, $urandom, $urandom, $urandom};
    left = stall_n[0];
    for (int c = 0; c < 200 && !done; c++) begin
      if (ifa.out_valid) begin
        done = 1'b1;
      end else begin
        check_eq({tag, "_key_req"}, 128'({ifa.rk_req, ifa.busy, ifa.start_ready, ifa.rk_idx,
                                          ifa.rnd_last}),
                 128'({1'b1, 1'b1, 1'b0, exp_idx, exp_idx == 4'd10}));
        ifa.rk_valid = (left == 0);
        if (left == 0) begin
          exp_idx = exp_idx + 4'd1;
          left    = stall_n[exp_idx];
        end else begin
          left--;
        end
        tick();
        lat++;
      end
    end
    ifa.rk_valid = 1'b0;
    check_eq({tag, "_done"}, 128'(done), 128'h1);
    check_eq({tag, "_latency"}, 128'(lat), 128'(11 + total_stall));
    check_eq({tag, "_ct"}, ifa.data_out, exp_ct);
    for (int b = 0; b < bp; b++) begin
      ifa.start_valid = 1'b1;
      ifa.data_in     = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check_eq({tag, "_bp_hold"}, 128'({ifa.out_valid, ifa.start_ready, ifa.busy}), 128'(3'b101));
      check_eq({tag, "_bp_ct"}, ifa.data_out, exp_ct);
    end
    ifa.start_valid = 1'b0;
    ifa.out_ready   = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    check_eq({tag, "_idle"}, 128'({ifa.out_valid, ifa.start_ready, ifa.busy, ifa.rk_req,
                                   ifa.rnd_last}), 128'(5'b01001));
    check_eq({tag, "_idle_ct"}, ifa.data_out, exp_ct);
  endtask

  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    logic [127:0] pt, p2, ct0, ct1, ck;
    int           acc0, acc1, nacc, nout, lat;
    bit           hit;

    build_sbox();
    expand_key({FIPS_KEY, 128'h0}, 4, 1'b0);
    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 1'b1);
    for (int i = 0; i < 16; i++) stall_n[i] = 0;
    ifa.start_valid = 1'b0; ifa.data_in = 128'h0; ifa.rk_valid = 1'b0; ifa.out_ready = 1'b0;
    ifb.start_valid = 1'b0; ifb.data_in = 128'h0; ifb.rk_valid = 1'b1; ifb.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_a("reset");

    // FIPS-197 App. B, no stalls, then with 3-cycle stalls at idx 0, 5, 10 and backpressure.
    run_block(FIPS_PT, FIPS_CT, 0, "fips");
    stall_n[0] = 3; stall_n[5] = 3; stall_n[10] = 3;
    run_block(FIPS_PT, FIPS_CT, 5, "fips_stall");
    for (int i = 0; i < 16; i++) stall_n[i] = 0;

    // Back-to-back with start_valid held high and out_ready tied high.
    p2 = {$urandom, $urandom, $urandom, $urandom};
    ifa.start_valid = 1'b1; ifa.data_in = FIPS_PT; ifa.rk_valid = 1'b1; ifa.out_ready = 1'b1;
    nacc = 0; nout = 0; acc0 = 0; acc1 = 0; ct0 = 128'h0; ct1 = 128'h0;
    for (int c = 0; c < 100 && nout < 2; c++) begin
      if (nacc >= 1) ifa.data_in = p2;
      if (ifa.out_valid) begin
        if (nout == 0) ct0 = ifa.data_out;
        else           ct1 = ifa.data_out;
        nout++;
      end
      if (ifa.start_ready && ifa.start_valid) begin
        if (nacc == 0) acc0 = c;
        else           acc1 = c;
        nacc++;
      end
      if (nout < 2) tick();
    end
    ifa.start_valid = 1'b0;
    tick();
    ifa.out_ready = 1'b0; ifa.rk_valid = 1'b0;
    check_eq("b2b_outputs", 128'(nout), 128'h2);
    check_eq("b2b_ct0", ct0, FIPS_CT);
    check_eq("b2b_ct1", ct1, aes_ref(p2, 10, 1'b0));
    check_eq("b2b_spacing", 128'(acc1 - acc0), 128'd13);
    check_eq("b2b_idle", 128'({ifa.start_ready, ifa.busy}), 128'(2'b10));

    // Reset at idx 4, then a fresh block.
    ifa.start_valid = 1'b1; ifa.data_in = FIPS_PT; ifa.rk_valid = 1'b1;
    tick();
    ifa.start_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (ifa.rk_idx == 4'd4) hit = 1'b1;
      else tick();
    end
    check_eq("midrst_reach_idx4", 128'(hit), 128'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ifa.rk_valid = 1'b0;
    check_reset_a("midrst");
    run_block(FIPS_PT, FIPS_CT, 1, "after_rst");

    // Randomized keys, plaintexts, key stalls and backpressure.
    for (int t = 0; t < 6; t++) begin
      ck = {$urandom, $urandom, $urandom, $urandom};
      expand_key({ck, 128'h0}, 4, 1'b0);
      for (int i = 0; i < 16; i++)
        stall_n[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      pt = {$urandom, $urandom, $urandom, $urandom};
      run_block(pt, aes_ref(pt, 10, 1'b0), int'($urandom_range(0, 3)), $sformatf("rnd%0d", t));
    end

    // NR=14 build with FIPS-197 App. C.3.
    ifb.start_valid = 1'b1; ifb.data_in = 128'h00112233445566778899aabbccddeeff;
    tick();
    ifb.start_valid = 1'b0;
    check_eq("nr14_req", 128'({ifb.rk_req, ifb.busy}), 128'(2'b11));
    lat = 1; hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      tick();
      if (ifb.out_valid) hit = 1'b1;
      else lat++;
    end
    check_eq("nr14_done", 128'(hit), 128'h1);
    check_eq("nr14_latency", 128'(lat), 128'd15);
    check_eq("nr14_ct", ifb.data_out, 128'h8ea2b7ca516745bfeafc49904b496089);
    check_eq("nr14_ct_model", ifb.data_out, aes_ref(128'h00112233445566778899aabbccddeeff, 14, 1'b1));
    check_eq("nr14_last", 128'({ifb.rnd_last, ifb.rk_idx}), 128'({1'b1, 4'd14}));
    ifb.out_ready = 1'b1;
    tick();
    ifb.out_ready = 1'b0;
    check_eq("nr14_idle", 128'({ifb.out_valid, ifb.start_ready, ifb.busy, ifb.rk_req}), 128'(4'b0100));
    check_eq("nr14_state", ifb.rnd_state, 128'h8ea2b7ca516745bfeafc49904b496089);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Iterative AES-128/192/256 encryption controller that sequences one 128-bit block through NR+1 round-key additions. It holds the state register, requests round keys by index from the key-schedule block, and feeds the external combinational round function (SubBytes/ShiftRows/MixColumns). It XORs each round key into the state and returns the ciphertext over a valid/ready handshake. It sits between the block-input interface and the key-expansion unit and owns all round sequencing.

Parameters:
DATA_W, 128, state/key width; only 128 is legal.
NR, 10, number of AES rounds; legal values are 10, 12 and 14.
RND_W, 4, width of the round counter and key index; must satisfy 2^RND_W > NR.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
start_valid  in  1  a new plaintext block is offered.
start_ready  out  1  sequencer can accept a block; high only in IDLE.
data_in  in  DATA_W  plaintext, sampled when start_valid && start_ready.
rk_req  out  1  round key requested; high only in KEY_WAIT.
rk_idx  out  RND_W  index of the requested round key, 0..NR.
rk_valid  in  1  round key for rk_idx is present on rk_data.
rk_data  in  DATA_W  round-key value.
rnd_state  out  DATA_W  current state register, driven to the external round function.
rnd_last  out  1  high when the round counter equals NR (round function skips MixColumns).
rnd_result  in  DATA_W  combinational round-function output for rnd_state.
out_valid  out  1  ciphertext is available; high only in DONE.
out_ready  in  1  downstream accepts the ciphertext.
data_out  out  DATA_W  ciphertext, equal to the state register.
busy  out  1  high when the state machine is not in IDLE.

Behaviour:
- Reset (synchronous, active-high) takes priority over everything, including a reset asserted mid-block:
  - FSM goes to IDLE; round counter and state register clear to 0.
  - In the cycle after reset: start_ready=1; rk_req=0, rk_idx=0, out_valid=0, busy=0, data_out=0, rnd_state=0, rnd_last=0.
  - An in-flight block is discarded.
- FSM has three states: IDLE, KEY_WAIT and DONE.
- IDLE:
  - start_ready=1.
  - On start_valid: state<=data_in, round<=0, go to KEY_WAIT.
- KEY_WAIT:
  - rk_req=1 and rk_idx=round.
  - While rk_valid=0, hold all registers.
  - On rk_valid=1, state<=(round==0 ? state : rnd_result) ^ rk_data.
  - Then, if round==NR, go to DONE; otherwise round<=round+1 and remain in KEY_WAIT.
  - rk_data is sampled only when rk_req && rk_valid.
- DONE:
  - out_valid=1 and data_out=state.
  - data_out and out_valid are held stable while out_ready=0.
  - On out_ready, go to IDLE; start_ready rises the next cycle, so there is no same-cycle re-accept.
- start_valid outside IDLE is ignored, and data_in is not sampled.
- rnd_last=(round==NR) in every state; rnd_state=state always.
- Latency: with rk_valid tied high, out_valid rises exactly NR+1 cycles after the accepting edge (11 cycles for NR=10).
  - Each cycle of rk_valid=0 in KEY_WAIT adds one cycle.
- Round counter never exceeds NR; no wrap-around is possible.
- Throughput: one block per NR+3 cycles minimum (accept, NR+1 key cycles, one DONE cycle with out_ready=1).
- rk_valid and out_ready are ignored outside KEY_WAIT and DONE respectively.

Test Plan:
- FIPS-197 App. B vector: reset, then offer data_in=3243f6a8885a308d313198a2e0370734 with the key schedule from 2b7e151628aed2a6abf7158809cf4f3c and rk_valid=1 -> out_valid 11 cycles after accept, data_out=3925841d02dc09fbdc118597196a0b32, rk_idx sequence 0..10, rnd_last high only at idx 10.
- Key stalls: same vector with rk_valid low for 3 cycles at idx 0, 5 and 10 -> identical ciphertext, latency 20 cycles, rk_idx held during each stall.
- Output backpressure: out_ready low for 5 cycles in DONE -> out_valid and data_out stable, start_ready=0, start_valid pulses ignored; after out_ready, IDLE and start_ready=1 on the next cycle.
- Back-to-back blocks: two FIPS vectors with start_valid held high and out_ready=1 -> both ciphertexts correct, second accept exactly NR+3 cycles after the first.
- Mid-operation reset: assert reset at idx 4 -> next cycle IDLE, all outputs at reset values; a subsequent fresh block produces the correct ciphertext.
- NR=14 build with the FIPS-197 App. C.3 AES-256 vector (pt 00112233445566778899aabbccddeeff) -> data_out=8ea2b7ca516745bfeafc49904b496089 after 15 key cycles.
